// File: rtl/seq_scan_arbiter.sv
// Round-robin arbiter sharing one programmable serial pattern detector among N_REQ bit streams.
// Overlapping matches are reported combinationally; per-burst match counts are reported at burst end.
module seq_scan_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PAT_W = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cfg_wr,
    input  logic [PAT_W-1:0]             cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
    output logic                         cfg_err,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ-1:0]             in_valid,
    input  logic [N_REQ-1:0]             in_bit,
    input  logic [N_REQ-1:0]             in_last,
    output logic [N_REQ-1:0]             gnt,
    output logic                         busy,
    output logic                         match,
    output logic                         done,
    output logic [$clog2(N_REQ)-1:0]     done_id,
    output logic [CNT_W-1:0]             done_count,
    output logic                         done_abort
);

    localparam int unsigned LEN_W = $clog2(PAT_W + 1);
    localparam int unsigned ID_W  = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    owner_q, last_id_q, pick_id;
    logic [PAT_W-1:0]   hist_q, pat_q, window, len_mask;
    logic [LEN_W-1:0]   bit_cnt_q, len_q;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_nx;
    logic               pick_found, end_abort, cfg_ok;
    logic               own_req, own_valid, own_bit, own_last, accept, enough;

    assign own_req   = req[owner_q];
    assign own_valid = in_valid[owner_q];
    assign own_bit   = in_bit[owner_q];
    assign own_last  = in_last[owner_q];

    // A bit is taken unless the owner is dropping req without closing the burst.
    assign accept   = (state_q == S_SCAN) && own_valid && (own_last || own_req);
    assign window   = PAT_W'({hist_q, own_bit});
    assign len_mask = PAT_W'(((PAT_W+1)'(1) << len_q) - (PAT_W+1)'(1));
    assign enough   = ({1'b0, bit_cnt_q} + (LEN_W+1)'(1)) >= {1'b0, len_q};
    assign match    = accept && enough && (((window ^ pat_q) & len_mask) == '0);

    assign match_cnt_nx = (match && !(&match_cnt_q)) ? match_cnt_q + CNT_W'(1) : match_cnt_q;
    assign cfg_ok = cfg_wr && (state_q == S_IDLE) && (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));

    // First requester strictly after last_id, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            if (!pick_found && req[ID_W'((32'(last_id_q) + k) % N_REQ)]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'((32'(last_id_q) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        end_abort = 1'b0;
        unique case (state_q)
            S_IDLE: if (|req) state_d = S_SCAN;
            S_SCAN: begin
                if (accept && own_last) begin
                    state_d = S_DONE;
                end else if (!own_req) begin
                    state_d   = S_DONE;
                    end_abort = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Burst datapath, configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q     <= '0;
            last_id_q   <= ID_W'(N_REQ - 1);
            hist_q      <= '0;
            bit_cnt_q   <= '0;
            match_cnt_q <= '0;
            pat_q       <= PAT_W'(2);
            len_q       <= LEN_W'(3);
            gnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            done_id     <= '0;
            done_count  <= '0;
            done_abort  <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err <= cfg_wr && !cfg_ok;
            if (cfg_ok) begin
                pat_q <= cfg_pattern;
                len_q <= cfg_len;
            end
            done <= 1'b0;
            busy <= (state_d != S_IDLE);
            unique case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        owner_q     <= pick_id;
                        hist_q      <= '0;
                        bit_cnt_q   <= '0;
                        match_cnt_q <= '0;
                        gnt         <= N_REQ'(1) << pick_id;
                    end
                end
                S_SCAN: begin
                    if (accept) begin
                        hist_q      <= window;
                        match_cnt_q <= match_cnt_nx;
                        if (bit_cnt_q != LEN_W'(PAT_W)) bit_cnt_q <= bit_cnt_q + LEN_W'(1);
                    end
                    if (state_d == S_DONE) begin
                        gnt        <= '0;
                        done       <= 1'b1;
                        done_id    <= owner_q;
                        done_count <= match_cnt_nx;
                        done_abort <= end_abort;
                    end
                end
                S_DONE:  last_id_q <= owner_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Bench for seq_scan_arbiter: vector table, directed corner sequences and random traffic
// against a burst-level reference model; a CNT_W=2 copy shares the stimulus for saturation.
module tb_seq_scan_arbiter;

    localparam int PH_IDLE = 0;
    localparam int PH_SCAN = 1;
    localparam int PH_DONE = 2;

    logic       clk;
    logic       reset, cfg_wr;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic [3:0] req, in_valid, in_bit, in_last;

    logic       cfg_err, busy, match, done, done_abort;
    logic [3:0] gnt;
    logic [1:0] done_id;
    logic [7:0] done_count;

    logic       cfg_err2, busy2, match2, done2, done_abort2;
    logic [3:0] gnt2;
    logic [1:0] done_id2;
    logic [1:0] done_count2;

    int errors = 0;
    int checks = 0;

    seq_scan_arbiter #(.N_REQ(4), .PAT_W(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_err(cfg_err), .req(req), .in_valid(in_valid), .in_bit(in_bit), .in_last(in_last),
        .gnt(gnt), .busy(busy), .match(match), .done(done), .done_id(done_id),
        .done_count(done_count), .done_abort(done_abort)
    );

    seq_scan_arbiter #(.N_REQ(4), .PAT_W(8), .CNT_W(2)) dut_w2 (
        .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_err(cfg_err2), .req(req), .in_valid(in_valid), .in_bit(in_bit), .in_last(in_last),
        .gnt(gnt2), .busy(busy2), .match(match2), .done(done2), .done_id(done_id2),
        .done_count(done_count2), .done_abort(done_abort2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: burst contents kept as a plain queue of received bits.
    bit       m_known = 0;
    int       m_state = PH_IDLE;
    int       m_owner = 0;
    int       m_last  = 3;
    int       m_count = 0;
    int       m_len   = 3;
    bit [7:0] m_pat   = 8'd2;
    bit       m_q[$];
    bit [3:0] e_gnt = 0;
    bit       e_busy = 0, e_done = 0, e_abort = 0, e_cfg_err = 0;
    int       e_id = 0, e_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_match(input logic [3:0] rq, input logic [3:0] v,
                                   input logic [3:0] b, input logic [3:0] l);
        int o, n;
        bit x;
        if (m_state != PH_SCAN) return 0;
        o = m_owner;
        if (!(v[o] && (l[o] || rq[o]))) return 0;
        n = m_q.size() + 1;
        if (n < m_len) return 0;
        for (int k = 0; k < m_len; k++) begin
            int pos;
            pos = n - m_len + k;
            x = (pos == n - 1) ? b[o] : m_q[pos];
            if (x != m_pat[m_len-1-k]) return 0;
        end
        return 1;
    endfunction

    task automatic model_edge(input bit rst, input logic [3:0] rq, input logic [3:0] v,
                              input logic [3:0] b, input logic [3:0] l, input bit cw,
                              input logic [7:0] cp, input logic [3:0] cl, input bit em);
        int o;
        if (rst) begin
            m_known = 1; m_state = PH_IDLE; m_owner = 0; m_last = 3; m_count = 0;
            m_q.delete(); m_pat = 8'd2; m_len = 3;
            e_gnt = 0; e_busy = 0; e_done = 0; e_id = 0; e_cnt = 0; e_abort = 0; e_cfg_err = 0;
            return;
        end
        e_done = 0;
        e_cfg_err = 0;
        if (cw) begin
            if (m_state == PH_IDLE && cl >= 1 && cl <= 8) begin
                m_pat = cp;
                m_len = int'(cl);
            end else begin
                e_cfg_err = 1;
            end
        end
        o = m_owner;
        case (m_state)
            PH_IDLE: begin
                if (rq != 0) begin
                    for (int k = 1; k <= 4; k++) begin
                        if (rq[(m_last + k) % 4]) begin
                            m_owner = (m_last + k) % 4;
                            break;
                        end
                    end
                    m_q.delete();
                    m_count = 0;
                    e_gnt   = 4'(1 << m_owner);
                    e_busy  = 1;
                    m_state = PH_SCAN;
                end
            end
            PH_SCAN: begin
                if (v[o] && (l[o] || rq[o])) begin
                    m_q.push_back(b[o]);
                    if (em) m_count++;
                end
                if ((v[o] && l[o]) || !rq[o]) begin
                    e_gnt   = 0;
                    e_done  = 1;
                    e_id    = o;
                    e_cnt   = m_count;
                    e_abort = !(v[o] && l[o]);
                    m_state = PH_DONE;
                end
            end
            default: begin
                m_last  = m_owner;
                m_state = PH_IDLE;
                e_busy  = 0;
            end
        endcase
    endtask

    // One clock: drive, check match mid-cycle, step the model at the edge, check registers.
    task automatic cyc(input bit rst, input logic [3:0] rq, input logic [3:0] v,
                       input logic [3:0] b, input logic [3:0] l, input bit cw,
                       input logic [7:0] cp, input logic [3:0] cl, output logic mm);
        bit em;
        reset = rst; req = rq; in_valid = v; in_bit = b; in_last = l;
        cfg_wr = cw; cfg_pattern = cp; cfg_len = cl;
        #4;
        em = m_match(rq, v, b, l);
        mm = match;
        if (m_known) begin
            chk("match", 32'(match), 32'(em));
            chk("match_w2", 32'(match2), 32'(em));
        end
        @(posedge clk);
        model_edge(rst, rq, v, b, l, cw, cp, cl, em);
        #1;
        if (m_known) begin
            chk("gnt", 32'(gnt), 32'(e_gnt));
            chk("gnt_w2", 32'(gnt2), 32'(e_gnt));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("done_id", 32'(done_id), 32'(e_id));
            chk("done_count", 32'(done_count), 32'((e_cnt > 255) ? 255 : e_cnt));
            chk("done_count_w2", 32'(done_count2), 32'((e_cnt > 3) ? 3 : e_cnt));
            chk("done_abort", 32'(done_abort), 32'(e_abort));
            chk("cfg_err", 32'(cfg_err), 32'(e_cfg_err));
        end
    endtask

    task automatic idle(input int n);
        logic mm;
        for (int i = 0; i < n; i++) cyc(0, 4'd0, 4'd0, 4'd0, 4'd0, 0, 8'd0, 4'd0, mm);
    endtask

    task automatic grant(input int o);
        logic mm;
        cyc(0, 4'(1 << o), 4'd0, 4'd0, 4'd0, 0, 8'd0, 4'd0, mm);
    endtask

    task automatic send(input int o, input bit bv, input bit lst, output logic mm);
        cyc(0, 4'(1 << o), 4'(1 << o), bv ? 4'(1 << o) : 4'd0, lst ? 4'(1 << o) : 4'd0,
            0, 8'd0, 4'd0, mm);
    endtask

    typedef struct {
        logic [3:0] rq, v, b, l;
        logic       em;
        logic [3:0] eg;
        logic       ed;
        logic [7:0] ec;
    } vec_t;

    vec_t       tbl[7];
    logic       mm;
    logic [3:0] mv;
    logic [3:0] grants[$];
    logic [3:0] rr_exp[5];
    logic [3:0] rr, rv, rb, rl, rc;
    logic [7:0] rp;
    bit         rw, rs;

    initial begin
        // Default pattern "010" with overlap, owner 0, starting from reset.
        tbl[0] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b0, 8'd0};
        tbl[1] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b0, 8'd0};
        tbl[2] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 8'd0};
        tbl[3] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 8'd0};
        tbl[4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 8'd0};
        tbl[5] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 4'b0000, 1'b1, 8'd2};
        tbl[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd2};
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        cyc(1, 4'd0, 4'd0, 4'd0, 4'd0, 0, 8'd0, 4'd0, mm);
        cyc(1, 4'd0, 4'd0, 4'd0, 4'd0, 0, 8'd0, 4'd0, mm);
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        idle(1);
        chk("reset_cfg_err", 32'(cfg_err), 32'd0);

        for (int i = 0; i < 7; i++) begin
            cyc(0, tbl[i].rq, tbl[i].v, tbl[i].b, tbl[i].l, 0, 8'd0, 4'd0, mm);
            chk("tbl_match", 32'(mm), 32'(tbl[i].em));
            chk("tbl_gnt", 32'(gnt), 32'(tbl[i].eg));
            chk("tbl_done", 32'(done), 32'(tbl[i].ed));
            chk("tbl_count", 32'(done_count), 32'(tbl[i].ec));
            if (i == 5) begin
                chk("tbl_done_id", 32'(done_id), 32'd0);
                chk("tbl_done_abort", 32'(done_abort), 32'd0);
            end
        end

        // Pattern "000": a burst of ones, then zeros from another requester.
        cyc(0, 4'd0, 4'd0, 4'd0, 4'd0, 1, 8'b0000_0000, 4'd3, mm);
        grant(0);
        for (int i = 0; i < 4; i++) send(0, 1, i == 3, mm);
        idle(1);
        chk("ones_count", 32'(done_count), 32'd0);
        grant(1);
        for (int i = 0; i < 4; i++) begin
            send(1, 0, i == 3, mm);
            mv[i] = mm;
        end
        chk("zeros_matches", 32'(mv), 32'b1100);
        chk("zeros_count", 32'(done_count), 32'd2);
        chk("zeros_id", 32'(done_id), 32'd1);
        idle(1);

        // Round robin from reset with everyone requesting one-bit bursts.
        cyc(1, 4'd0, 4'd0, 4'd0, 4'd0, 0, 8'd0, 4'd0, mm);
        for (int i = 0; i < 13; i++) begin
            cyc(0, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 0, 8'd0, 4'd0, mm);
            if (gnt != 4'd0) grants.push_back(gnt);
        end
        chk("rr_grant_count", 32'(grants.size()), 32'd5);
        for (int i = 0; i < 5 && i < grants.size(); i++) chk("rr_order", 32'(grants[i]), 32'(rr_exp[i]));
        cyc(0, 4'd0, 4'd0, 4'd0, 4'd0, 0, 8'd0, 4'd0, mm);
        idle(1);

        // Abort by req drop, then in_last racing a req drop.
        grant(2);
        send(2, 1, 0, mm);
        send(2, 1, 0, mm);
        cyc(0, 4'd0, 4'd0, 4'd0, 4'd0, 0, 8'd0, 4'd0, mm);
        chk("abort_flag", 32'(done_abort), 32'd1);
        chk("abort_id", 32'(done_id), 32'd2);
        chk("abort_count", 32'(done_count), 32'd0);
        idle(1);
        grant(3);
        send(3, 0, 0, mm);
        cyc(0, 4'd0, 4'b1000, 4'd0, 4'b1000, 0, 8'd0, 4'd0, mm);
        chk("last_drop_abort", 32'(done_abort), 32'd0);
        chk("last_drop_id", 32'(done_id), 32'd3);
        idle(1);

        // Config guard: write during a burst, then illegal lengths.
        grant(0);
        cyc(0, 4'b0001, 4'd0, 4'd0, 4'd0, 1, 8'hFF, 4'd2, mm);
        chk("cfg_err_scan", 32'(cfg_err), 32'd1);
        send(0, 0, 0, mm);
        send(0, 1, 0, mm);
        send(0, 0, 1, mm);
        chk("guard_match", 32'(mm), 32'd1);
        idle(1);
        cyc(0, 4'd0, 4'd0, 4'd0, 4'd0, 1, 8'hFF, 4'd0, mm);
        chk("cfg_err_len0", 32'(cfg_err), 32'd1);
        cyc(0, 4'd0, 4'd0, 4'd0, 4'd0, 1, 8'hFF, 4'd9, mm);
        chk("cfg_err_len9", 32'(cfg_err), 32'd1);
        idle(1);
        chk("cfg_err_clear", 32'(cfg_err), 32'd0);
        grant(1);
        send(1, 0, 0, mm);
        send(1, 1, 0, mm);
        send(1, 0, 1, mm);
        chk("still_010", 32'(mm), 32'd1);
        idle(1);
        // Config accepted in the grant cycle governs that burst: pattern "11".
        cyc(0, 4'b0100, 4'd0, 4'd0, 4'd0, 1, 8'b0000_0011, 4'd2, mm);
        chk("grant_cfg_err", 32'(cfg_err), 32'd0);
        send(2, 1, 0, mm);
        send(2, 1, 1, mm);
        chk("grant_cfg_match", 32'(mm), 32'd1);
        idle(1);

        // Five overlapping "010" matches: full count vs. 2-bit saturated count.
        cyc(0, 4'd0, 4'd0, 4'd0, 4'd0, 1, 8'b0000_0010, 4'd3, mm);
        grant(3);
        for (int i = 0; i < 11; i++) send(3, i % 2 == 1, i == 10, mm);
        chk("sat_count_w8", 32'(done_count), 32'd5);
        chk("sat_count_w2", 32'(done_count2), 32'd3);
        idle(1);

        // Reset in the middle of a burst.
        grant(0);
        send(0, 1, 0, mm);
        cyc(1, 4'b0001, 4'b0001, 4'd0, 4'd0, 0, 8'd0, 4'd0, mm);
        chk("midreset_gnt", 32'(gnt), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);

        // Random traffic.
        rr = 4'd0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(15) == 0) rr[i] = ~rr[i];
            rv = 4'($urandom);
            rb = 4'($urandom);
            for (int i = 0; i < 4; i++) rl[i] = ($urandom_range(5) == 0);
            for (int i = 0; i < 4; i++) if (!rr[i] && !rl[i]) rv[i] = 1'b0;
            rw = ($urandom_range(9) == 0);
            rc = ($urandom_range(3) == 0) ? 4'($urandom_range(9)) : 4'($urandom_range(3, 1));
            rp = 8'($urandom);
            rs = ($urandom_range(499) == 0);
            cyc(rs, rr, rv, rb, rl, rw, rp, rc, mm);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_scan_arbiter.md
# seq_scan_arbiter

Round-robin scheduler that shares one programmable serial sequence-detector engine among `N_REQ` bit-stream requesters. A requester raises `req` and gets an exclusive grant. It then streams a burst of bits, and the engine flags every occurrence of the configured pattern, overlaps included, with a Mealy-style `match` in the same cycle as the completing bit. At burst end the block reports the owner and its match count, then re-arbitrates.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `PAT_W`, 8, maximum pattern length in bits
- `CNT_W`, 8, width of per-burst match counter
- `clk`  in  1  clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `cfg_wr`  in  1  write `cfg_pattern`/`cfg_len`
- `cfg_pattern`  in  PAT_W  pattern; bit `cfg_len-1` = first bit received, bit 0 = last
- `cfg_len`  in  $clog2(PAT_W+1)  pattern length, legal 1..PAT_W
- `cfg_err`  out  1  one-cycle pulse: config write rejected
- `req`  in  N_REQ  per-requester access request
- `in_valid`  in  N_REQ  per-requester bit strobe
- `in_bit`  in  N_REQ  per-requester serial data
- `in_last`  in  N_REQ  per-requester final bit of burst
- `gnt`  out  N_REQ  registered one-hot grant
- `busy`  out  1  state is not IDLE
- `match`  out  1  combinational: owner's current bit completes the pattern
- `done`  out  1  one-cycle burst-complete pulse
- `done_id`  out  $clog2(N_REQ)  owner index of finished burst
- `done_count`  out  CNT_W  matches in finished burst
- `done_abort`  out  1  burst ended by owner dropping `req`

## Operation
- States: IDLE, SCAN, DONE.
- **IDLE**
  - `gnt`=0.
  - If `req`≠0, pick the first requesting index after `last_id`, searching upward with wrap.
  - Load `owner`, clear history, `bit_cnt` and `match_cnt`, set `gnt[owner]`, and go to SCAN.
- **SCAN** (only `owner`'s `in_valid`/`in_bit`/`in_last`/`req` are observed; all others are ignored)
  - The owner bit is accepted when `in_valid[owner]`.
  - History shifts left by one, taking `in_bit` at bit 0.
  - `bit_cnt` increments, saturating at PAT_W.
  - `match` = SCAN & `in_valid[owner]` & (`bit_cnt`+1 ≥ `cfg_len`) & ({history, `in_bit`}[cfg_len-1:0] == `cfg_pattern`[cfg_len-1:0]).
  - Bits from before the burst never contribute to a match.
  - On `match`, `match_cnt` increments, saturating at 2^CNT_W−1.
  - If the accepted bit has `in_last[owner]`, go to DONE with `abort`=0. A match on the last bit is counted.
  - Else if `req[owner]`=0, go to DONE with `abort`=1. No bit is accepted in that cycle.
  - `in_last` takes priority over a simultaneous `req` drop.
- **DONE**
  - `gnt`=0, `done`=1, `done_id`=`owner`, `done_count`=`match_cnt`, `done_abort`=`abort`.
  - `last_id` ← `owner`, then go to IDLE.
- **Config**
  - `cfg_wr` is accepted only in IDLE and only with `cfg_len` in 1..PAT_W.
  - Otherwise the old value is kept and `cfg_err` pulses in the next cycle.
  - A write accepted in the same cycle as a grant applies to the granted burst.
- `done_id`/`done_count`/`done_abort` hold their values until the next DONE.

## Timing
- Reset values:
  - IDLE.
  - `gnt`=0, `busy`=0, `done`=0, `cfg_err`=0, `done_id`=0, `done_count`=0, `done_abort`=0.
  - `cfg_pattern`=8'b0000_0010 (pattern "010"), `cfg_len`=3.
  - `last_id`=N_REQ−1, so index 0 wins first.
  - Counters and history are cleared.
- Reset mid-burst drops everything immediately: no `done` pulse, and `gnt`=0 on the next cycle.
- Grant latency: `req` sampled in IDLE at cycle t gives `gnt` at t+1, and bits are accepted from t+1.
- `match` has zero latency: it is asserted in the same cycle as the completing `in_valid`.
- Burst end: `in_last` (or `req` drop) at t gives `done`=1 with `gnt`=0 at t+1, IDLE at t+2, and the earliest next `gnt` at t+3.
- `gnt` is never asserted in IDLE or DONE, and at most one bit is set at any time.

## Test plan
- **Reset defaults:** assert `reset` 2 cycles → `gnt`=0, `busy`=0, `done`=0; then `cfg_err`=0 with `cfg_wr`=0.
- **Default pattern, overlap:** req0 streams 0,1,0,1,0 (last on 5th) → `match` on bits 3 and 5; `done` pulse one cycle later with `done_id`=0, `done_count`=2, `done_abort`=0.
- **History cleared:** config "000" (len 3); req1 streams 0,0,0,0 → `match` only on bits 3 and 4; `done_count`=2. A preceding burst of 1s from req0 does not cause an early match.
- **Round-robin:** `req`=4'b1111 held, each owner sends 1-bit bursts → grant order 0,1,2,3,0. Each `gnt` is one cycle after IDLE and there is never more than one owner.
- **Abort:** owner 2 drops `req` after 2 bits → `done_abort`=1, `done_id`=2, `done_count`=0. Same-cycle `in_last` and `req` drop → `done_abort`=0.
- **Config guard:** `cfg_wr` during SCAN, or `cfg_len`=0 or 9 → `cfg_err` pulses, pattern is unchanged, and the next burst still matches "010". Counter saturation with CNT_W=2 and 5 matches → `done_count`=3.
